// File: rtl/v_red_seq.sv
// Sequencer for the AND/OR/XOR vector reduction pipeline: fetches vs2 beats, pads the tail, waits for the result.
// Build option: define VRED_SEW64_EN to process sew=3 commands; otherwise they complete immediately with err=1.
module v_red_seq #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned OPSEL_WIDTH = 2,
    parameter int unsigned SEW_WIDTH   = 2,
    parameter int unsigned VL_WIDTH    = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [OPSEL_WIDTH-1:0] cmd_opsel,
    input  logic [SEW_WIDTH-1:0]   cmd_sew,
    input  logic [VL_WIDTH-1:0]    cmd_vl,
    input  logic [ADDR_WIDTH-1:0]  cmd_src_addr,
    input  logic [ADDR_WIDTH-1:0]  cmd_dst_addr,
    input  logic [DATA_WIDTH-1:0]  cmd_scalar,
    output logic                   rd_valid,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic                   rd_ready,
    input  logic                   rd_data_valid,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   red_valid,
    output logic                   red_start,
    output logic                   red_end,
    output logic [DATA_WIDTH-1:0]  red_vec0,
    output logic [DATA_WIDTH-1:0]  red_vec1,
    output logic [OPSEL_WIDTH-1:0] red_opsel,
    output logic [SEW_WIDTH-1:0]   red_sew,
    output logic [ADDR_WIDTH-1:0]  red_addr,
    input  logic                   red_out_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned BPB     = DATA_WIDTH / 8;
    localparam int unsigned BPB_LOG = $clog2(BPB);
    localparam int unsigned TOT_W   = VL_WIDTH + 3;
    localparam int unsigned SUM_W   = VL_WIDTH + 4;
    localparam int unsigned CNT_W   = VL_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    state_e                 state_q;
    logic                   cmd_ready_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic                   rd_valid_q;
    logic [ADDR_WIDTH-1:0]  rd_addr_q;
    logic [CNT_W-1:0]       req_cnt_q;
    logic [CNT_W-1:0]       beat_cnt_q;
    logic [CNT_W-1:0]       nbeat_q;
    logic [BPB_LOG-1:0]     tail_q;
    logic                   red_valid_q;
    logic                   red_start_q;
    logic                   red_end_q;
    logic [DATA_WIDTH-1:0]  red_vec0_q;
    logic [DATA_WIDTH-1:0]  red_vec1_q;
    logic [OPSEL_WIDTH-1:0] opsel_q;
    logic [SEW_WIDTH-1:0]   sew_q;
    logic [ADDR_WIDTH-1:0]  dst_q;

    logic [TOT_W-1:0]       tot_d;
    logic [CNT_W-1:0]       nbeat_d;
    logic [BPB_LOG-1:0]     tail_d;
    logic                   reject_d;
    logic                   last_beat_d;
    logic [7:0]             pad_byte_d;
    logic [DATA_WIDTH-1:0]  vec0_d;

    // Command geometry, rejection and tail padding of the incoming beat.
    always_comb begin
        tot_d       = TOT_W'(cmd_vl) << cmd_sew;
        nbeat_d     = CNT_W'((SUM_W'(tot_d) + SUM_W'(BPB - 1)) >> BPB_LOG);
        tail_d      = tot_d[BPB_LOG-1:0];
`ifdef VRED_SEW64_EN
        reject_d    = 1'b0;
`else
        reject_d    = (cmd_sew == SEW_WIDTH'(3));
`endif
        last_beat_d = (beat_cnt_q == (nbeat_q - CNT_W'(1)));
        pad_byte_d  = (opsel_q == OPSEL_WIDTH'(1)) ? 8'hFF : 8'h00;
        vec0_d      = rd_data;
        if (last_beat_d && (tail_q != '0)) begin
            for (int i = 0; i < int'(BPB); i++) begin
                if (i >= int'(tail_q)) begin
                    vec0_d[i*8 +: 8] = pad_byte_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            req_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            nbeat_q     <= '0;
            tail_q      <= '0;
            red_valid_q <= 1'b0;
            red_start_q <= 1'b0;
            red_end_q   <= 1'b0;
            red_vec0_q  <= '0;
            red_vec1_q  <= '0;
            opsel_q     <= '0;
            sew_q       <= '0;
            dst_q       <= '0;
        end else begin
            done_q      <= 1'b0;
            red_valid_q <= 1'b0;
            red_start_q <= 1'b0;
            red_end_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        opsel_q     <= cmd_opsel;
                        sew_q       <= cmd_sew;
                        dst_q       <= cmd_dst_addr;
                        red_vec1_q  <= cmd_scalar;
                        nbeat_q     <= nbeat_d;
                        tail_q      <= tail_d;
                        req_cnt_q   <= '0;
                        beat_cnt_q  <= '0;
                        if ((cmd_vl == '0) || reject_d) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            err_q   <= reject_d;
                        end else begin
                            state_q    <= READ;
                            rd_valid_q <= 1'b1;
                            rd_addr_q  <= cmd_src_addr;
                        end
                    end
                end
                READ: begin
                    if (rd_valid_q && rd_ready) begin
                        req_cnt_q <= req_cnt_q + CNT_W'(1);
                        rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
                        if ((req_cnt_q + CNT_W'(1)) == nbeat_q) begin
                            rd_valid_q <= 1'b0;
                        end
                    end
                    if (rd_data_valid) begin
                        red_valid_q <= 1'b1;
                        red_start_q <= (beat_cnt_q == '0);
                        red_end_q   <= last_beat_d;
                        red_vec0_q  <= vec0_d;
                        beat_cnt_q  <= beat_cnt_q + CNT_W'(1);
                        if (last_beat_d) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (red_out_valid) begin
                        done_q      <= 1'b1;
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                FIN: begin
                    err_q       <= 1'b0;
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_valid  = rd_valid_q;
    assign rd_addr   = rd_addr_q;
    assign red_valid = red_valid_q;
    assign red_start = red_start_q;
    assign red_end   = red_end_q;
    assign red_vec0  = red_vec0_q;
    assign red_vec1  = red_vec1_q;
    assign red_opsel = opsel_q;
    assign red_sew   = sew_q;
    assign red_addr  = dst_q;

endmodule
